wb_select_stage: RTL and testbench

Registered, parametrised writeback-select stage between the memory stage and the register file. Each cycle it selects the value for `rd` from one of four sources: ALU result, load data, link address or upper immediate. It then registers the selected value with its destination and write enable, and presents it through a valid/ready handshake. A two-entry skid buffer absorbs register-file backpressure without losing a writeback, and a retire counter counts completed writebacks.

---
 rtl/wb_pkg.sv | 19 +
 rtl/wb_load_ext.sv | 14 +
 rtl/wb_select_stage.sv | 99 +++++++++
 tb/tb_wb_select_stage.sv | 133 +++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared encodings and types for the writeback-select stage.
package wb_pkg;
  localparam logic [1:0] WB_SRC_ALU = 2'd0;
  localparam logic [1:0] WB_SRC_MEM = 2'd1;
  localparam logic [1:0] WB_SRC_LINK = 2'd2;
  localparam logic [1:0] WB_SRC_IMM = 2'd3;
  localparam logic [2:0] LD_B = 3'b000;
  localparam logic [2:0] LD_H = 3'b001;
  localparam logic [2:0] LD_W = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;
  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} wb_state_t;
  // Destination part of a writeback entry; the XLEN-wide data field is added
  // by the stage so the entry width follows its XLEN parameter.
  typedef struct packed {
    logic [4:0] rd;
    logic we;
  } wb_ctl_t;
endpackage

// File: rtl/wb_load_ext.sv
// wb_load_ext: combinational load sign/zero extension selected by funct3.
module wb_load_ext import wb_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] din,
  output logic [XLEN-1:0] dout
);
  always_comb
    dout = funct3 == LD_B  ? {{(XLEN-8){din[7]}}, din[7:0]} :
           funct3 == LD_H  ? {{(XLEN-16){din[15]}}, din[15:0]} :
           funct3 == LD_BU ? XLEN'(din[7:0]) :
           funct3 == LD_HU ? XLEN'(din[15:0]) : din;
endmodule

// File: rtl/wb_select_stage.sv
// wb_select_stage: registered writeback source select with 2-entry skid buffer
// and retire counter; define WB_LOAD_EXT_EN to extend load data by funct3.
module wb_select_stage import wb_pkg::*; #(
  parameter int XLEN = 32,
  parameter int LINK_INC = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [XLEN-1:0]  in_alu,
  input  logic [XLEN-1:0]  in_mem,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [2:0]       in_funct3,
  input  logic [4:0]       in_rd,
  input  logic             in_we,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [4:0]       out_rd,
  output logic             out_we,
  output logic [CNT_W-1:0] retire_cnt
);
  typedef struct packed {
    logic [XLEN-1:0] data;
    wb_ctl_t ctl;
  } wb_entry_t;
  wb_state_t state, state_n;
  wb_entry_t main_q, skid_q, new_e;
  logic [XLEN-1:0] mem_data;
  logic ready_q, in_xfer, out_xfer, load_main, load_skid, main_from_skid;
`ifdef WB_LOAD_EXT_EN
  wb_load_ext #(.XLEN(XLEN)) u_load_ext (
    .funct3(in_funct3),
    .din(in_mem),
    .dout(mem_data)
  );
`else
  logic unused_funct3;
  assign unused_funct3 = ^in_funct3;
  assign mem_data = in_mem;
`endif
  always_comb begin
    new_e.data = in_sel == WB_SRC_ALU ? in_alu :
                 in_sel == WB_SRC_MEM ? mem_data :
                 in_sel == WB_SRC_LINK ? in_pc + XLEN'(LINK_INC) : in_imm;
    new_e.ctl.rd = in_rd;
    new_e.ctl.we = in_we && in_rd != 5'd0;
  end
  assign in_xfer = in_valid && ready_q;
  assign out_xfer = out_valid && out_ready;
  always_comb begin
    state_n = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      ST_EMPTY: if (in_xfer) begin
        load_main = 1'b1;
        state_n = ST_ONE;
      end
      ST_ONE: if (out_xfer && in_xfer) load_main = 1'b1;
        else if (out_xfer) state_n = ST_EMPTY;
        else if (in_xfer) begin
          load_skid = 1'b1;
          state_n = ST_FULL;
        end
      ST_FULL: if (out_xfer) begin
        main_from_skid = 1'b1;
        state_n = ST_ONE;
      end
      default: state_n = ST_EMPTY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
      main_q <= '0;
      skid_q <= '0;
      ready_q <= 1'b0;
      retire_cnt <= '0;
    end else begin
      state <= state_n;
      ready_q <= state_n != ST_FULL;
      if (load_main) main_q <= new_e;
      else if (main_from_skid) main_q <= skid_q;
      if (load_skid) skid_q <= new_e;
      retire_cnt <= retire_cnt + CNT_W'(out_xfer);
    end
  end
  assign in_ready = ready_q;
  assign out_valid = state != ST_EMPTY;
  assign out_data = main_q.data;
  assign out_rd = main_q.ctl.rd;
  assign out_we = main_q.ctl.we;
endmodule

// File: tb/tb_wb_select_stage.sv
// tb_wb_select_stage: directed self-checking bench for wb_select_stage.
module tb_wb_select_stage;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, in_we, out_valid, out_ready, out_we;
  logic [1:0] in_sel;
  logic [31:0] in_alu, in_mem, in_pc, in_imm, out_data, retire_cnt;
  logic [2:0] in_funct3;
  logic [4:0] in_rd, out_rd;
  int compared = 0;
  int mismatched = 0;

  wb_select_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_alu(in_alu), .in_mem(in_mem), .in_pc(in_pc),
    .in_imm(in_imm), .in_funct3(in_funct3), .in_rd(in_rd), .in_we(in_we),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_we(out_we), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

`ifdef WB_LOAD_EXT_EN
  localparam logic [31:0] EXP_LB = 32'hFFFF_FFF0;
  localparam logic [31:0] EXP_LBU = 32'h0000_00F0;
  localparam logic [31:0] EXP_LH = 32'hFFFF_80F0;
`else
  localparam logic [31:0] EXP_LB = 32'h0000_80F0;
  localparam logic [31:0] EXP_LBU = 32'h0000_80F0;
  localparam logic [31:0] EXP_LH = 32'h0000_80F0;
`endif

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0; in_sel = 2'd0;
    in_alu = 32'h11; in_mem = 32'h22; in_pc = 32'h1000; in_imm = 32'hABCD_0000;
    in_funct3 = 3'b010; in_rd = 5'd5; in_we = 1'b1;
    tick(); tick(); tick();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_rd", out_rd, 0);
    check("rst_we", out_we, 0);
    check("rst_cnt", retire_cnt, 0);
    check("rst_ready", in_ready, 0);
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    check("ready_after_rst", in_ready, 1);
    check("valid_after_rst", out_valid, 0);

    out_ready = 1'b1; in_valid = 1'b1;
    in_sel = 2'd0; tick();
    check("sel_alu", out_data, 32'h11);
    check("sel_alu_rd", out_rd, 5);
    check("sel_alu_we", out_we, 1);
    in_sel = 2'd1; tick();
    check("sel_mem", out_data, 32'h22);
    in_sel = 2'd2; tick();
    check("sel_link", out_data, 32'h1004);
    in_sel = 2'd3; tick();
    check("sel_imm", out_data, 32'hABCD_0000);
    check("sel_cnt3", retire_cnt, 3);
    in_valid = 1'b0; tick();
    check("sel_cnt4", retire_cnt, 4);
    check("sel_drained", out_valid, 0);

    out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd0;
    in_alu = 32'hA1; in_rd = 5'd1; tick();
    check("bp_ready1", in_ready, 1);
    in_alu = 32'hB2; in_rd = 5'd2; tick();
    check("bp_full_ready", in_ready, 0);
    in_alu = 32'hC3; in_rd = 5'd3; tick();
    check("bp_hold_data", out_data, 32'hA1);
    check("bp_hold_rd", out_rd, 1);
    check("bp_hold_ready", in_ready, 0);
    out_ready = 1'b1; tick();
    check("bp_out2", out_data, 32'hB2);
    check("bp_cnt5", retire_cnt, 5);
    check("bp_ready_back", in_ready, 1);
    tick();
    check("bp_out3", out_data, 32'hC3);
    check("bp_out3_rd", out_rd, 3);
    check("bp_cnt6", retire_cnt, 6);
    in_valid = 1'b0; tick();
    check("bp_cnt7", retire_cnt, 7);
    check("bp_drained", out_valid, 0);

    out_ready = 1'b0; in_valid = 1'b1; in_rd = 5'd0; in_we = 1'b1; tick();
    check("x0_valid", out_valid, 1);
    check("x0_we", out_we, 0);
    check("x0_rd", out_rd, 0);
    in_valid = 1'b0; out_ready = 1'b1; tick();
    check("x0_cnt", retire_cnt, 8);

    in_valid = 1'b1; in_sel = 2'd1; in_mem = 32'h0000_80F0; in_rd = 5'd7;
    in_funct3 = 3'b000; tick();
    check("ld_b", out_data, EXP_LB);
    in_funct3 = 3'b100; tick();
    check("ld_bu", out_data, EXP_LBU);
    in_funct3 = 3'b001; tick();
    check("ld_h", out_data, EXP_LH);
    in_valid = 1'b0; tick();
    check("ld_cnt", retire_cnt, 11);

    out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd0;
    in_alu = 32'hD4; tick();
    in_alu = 32'hE5; tick();
    check("mr_full", in_ready, 0);
    rst_n = 1'b0; in_valid = 1'b0; tick();
    check("mr_valid", out_valid, 0);
    check("mr_cnt", retire_cnt, 0);
    check("mr_ready", in_ready, 0);
    rst_n = 1'b1; out_ready = 1'b1; tick();
    check("mr_ready_back", in_ready, 1);
    check("mr_valid1", out_valid, 0);
    tick();
    check("mr_valid2", out_valid, 0);
    check("mr_cnt2", retire_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
